// File: rtl/pli_assert_monitor_pkg.sv
// Shared types for the run-time checker: error codes and a population-count helper.
package pli_pkg;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_MSG         = 3'd1,
    ERR_ASSERT      = 3'd2,
    ERR_AMONE       = 3'd3,
    ERR_ONEHOT      = 3'd4,
    ERR_ACK_NO_REQ  = 3'd5,
    ERR_REQ_BUSY    = 3'd6,
    ERR_ACK_TIMEOUT = 3'd7
  } err_code_e;

  // Callers zero-extend narrower vectors into the 64-bit argument.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + 7'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/pli_assert_monitor_if.sv
// Single-cycle request/acknowledge bus observed by the checker.
interface pli_assert_monitor_if #(
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_data;

  modport master (output bus_req, bus_ack, bus_data);
  modport slave  (input  bus_req, bus_ack, bus_data);
endinterface

// File: rtl/pli_assert_monitor_req_ack_checker.sv
// Tracks one outstanding request and strobes ack-without-request, request-while-busy
// and acknowledge-timeout failures for the current cycle.
module pli_req_ack_checker #(
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pli_assert_monitor_if.slave  bus,
  output logic                 req_pending,
  output logic [DATA_W-1:0]    req_data,
  output logic                 ack_no_req,
  output logic                 req_busy,
  output logic                 ack_timeout
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] tcnt;
  logic          accept;

  // An ack that closes the open request frees the slot for a same-cycle request.
  always_comb begin
    accept      = bus.bus_req && (!req_pending || bus.bus_ack);
    ack_no_req  = bus.bus_ack && !req_pending;
    req_busy    = bus.bus_req && req_pending && !bus.bus_ack;
    ack_timeout = req_pending && !bus.bus_ack && (tcnt == TW'(ACK_TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_pending <= 1'b0;
      req_data    <= '0;
      tcnt        <= '0;
    end else if (accept) begin
      req_pending <= 1'b1;
      req_data    <= bus.bus_data;
      tcnt        <= '0;
    end else if ((bus.bus_ack && req_pending) || ack_timeout) begin
      req_pending <= 1'b0;
      tcnt        <= '0;
    end else if (req_pending) begin
      tcnt        <= tcnt + 1'b1;
    end
  end

endmodule

// File: rtl/pli_assert_monitor.sv
// Top-level message/error accounting: saturating counters, first-error code latch,
// one-hot checks and a stop request once the error limit is reached.
module pli_assert_monitor
  import pli_pkg::*;
#(
  parameter int W           = 8,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int ERR_LIMIT   = 1,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                info_v,
  input  logic                warn_v,
  input  logic                err_v,
  input  logic                assert_en,
  input  logic                assert_cond,
  input  logic                amone_en,
  input  logic [W-1:0]        amone_vec,
  input  logic                onehot_en,
  input  logic [W-1:0]        onehot_vec,
  pli_assert_monitor_if.slave bus,
  output logic [CNT_W-1:0]    info_cnt,
  output logic [CNT_W-1:0]    warn_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [2:0]          err_code,
  output logic                err_sticky,
  output logic                stop_req,
  output logic                req_pending,
  output logic [DATA_W-1:0]   req_data
);

  logic [7:1]     fail;
  logic [2:0]     n_fail;
  logic [CNT_W:0] err_sum;
  logic [CNT_W-1:0] err_next;
  err_code_e      first_code;
  err_code_e      code_q;
  logic           ack_no_req, req_busy, ack_timeout;

  pli_req_ack_checker #(
    .DATA_W      (DATA_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_req_ack (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .req_pending (req_pending),
    .req_data    (req_data),
    .ack_no_req  (ack_no_req),
    .req_busy    (req_busy),
    .ack_timeout (ack_timeout)
  );

  // Bit i of fail is the strobe for error code i; the lowest set bit wins the latch.
  always_comb begin
    fail[1] = err_v;
    fail[2] = assert_en && !assert_cond;
    fail[3] = amone_en && (popcount(64'(amone_vec)) > 7'd1);
    fail[4] = onehot_en && (popcount(64'(onehot_vec)) != 7'd1);
    fail[5] = ack_no_req;
    fail[6] = req_busy;
    fail[7] = ack_timeout;
    n_fail  = 3'(popcount(64'(fail)));
    first_code = ERR_NONE;
    for (int i = 7; i >= 1; i--) begin
      if (fail[i]) first_code = err_code_e'(3'(i));
    end
    err_sum  = {1'b0, err_cnt} + (CNT_W + 1)'(n_fail);
    err_next = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      info_cnt   <= '0;
      warn_cnt   <= '0;
      err_cnt    <= '0;
      code_q     <= ERR_NONE;
      err_sticky <= 1'b0;
      stop_req   <= 1'b0;
    end else begin
      if (info_v && (info_cnt != '1)) info_cnt <= info_cnt + 1'b1;
      if (warn_v && (warn_cnt != '1)) warn_cnt <= warn_cnt + 1'b1;
      err_cnt <= err_next;
      if ((code_q == ERR_NONE) && (|fail)) code_q <= first_code;
      err_sticky <= err_sticky || (|fail);
      stop_req   <= stop_req || (err_next >= CNT_W'(ERR_LIMIT));
    end
  end

  assign err_code = code_q;

endmodule

// File: tb/tb_pli_assert_monitor.sv
// Directed-vector bench: the driver queues hand-computed expected outputs and a
// separate monitor compares them one edge after each stimulus is sampled.
module tb_pli_assert_monitor;

  localparam int W      = 3;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [15:0] info;
    logic [15:0] warn;
    logic [15:0] err;
    logic [2:0]  code;
    logic        sticky;
    logic        stop;
    logic        pend;
    logic [31:0] data;
  } exp_t;

  typedef struct packed {
    logic        info;
    logic        warn;
    logic        errv;
    logic        aen;
    logic        acond;
    logic        amen;
    logic [2:0]  amvec;
    logic        ohen;
    logic [2:0]  ohvec;
    logic        req;
    logic        ack;
    logic [31:0] data;
  } stim_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic info_v, warn_v, err_v, assert_en, assert_cond, amone_en, onehot_en;
  logic [W-1:0] amone_vec, onehot_vec;
  logic [CNT_W-1:0] info_cnt, warn_cnt, err_cnt;
  logic [2:0] err_code;
  logic err_sticky, stop_req, req_pending;
  logic [DATA_W-1:0] req_data;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  e;
  stim_t s;
  int compared = 0;
  int mismatched = 0;

  pli_assert_monitor_if #(.DATA_W(DATA_W)) bus ();

  pli_assert_monitor #(
    .W(W), .DATA_W(DATA_W), .CNT_W(CNT_W), .ERR_LIMIT(1), .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .info_v(info_v), .warn_v(warn_v), .err_v(err_v),
    .assert_en(assert_en), .assert_cond(assert_cond),
    .amone_en(amone_en), .amone_vec(amone_vec),
    .onehot_en(onehot_en), .onehot_vec(onehot_vec),
    .bus(bus),
    .info_cnt(info_cnt), .warn_cnt(warn_cnt), .err_cnt(err_cnt),
    .err_code(err_code), .err_sticky(err_sticky), .stop_req(stop_req),
    .req_pending(req_pending), .req_data(req_data)
  );

  always #5 clk = ~clk;

  task automatic cmpField(input string tag, input string name,
                          input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s.%s actual=%0h required=%0h", tag, name, act, req);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t x);
    cmpField(tag, "info_cnt",    32'(info_cnt),    32'(x.info));
    cmpField(tag, "warn_cnt",    32'(warn_cnt),    32'(x.warn));
    cmpField(tag, "err_cnt",     32'(err_cnt),     32'(x.err));
    cmpField(tag, "err_code",    32'(err_code),    32'(x.code));
    cmpField(tag, "err_sticky",  32'(err_sticky),  32'(x.sticky));
    cmpField(tag, "stop_req",    32'(stop_req),    32'(x.stop));
    cmpField(tag, "req_pending", 32'(req_pending), 32'(x.pend));
    cmpField(tag, "req_data",    req_data,         x.data);
  endtask

  task automatic drive(input stim_t d);
    info_v       = d.info;
    warn_v       = d.warn;
    err_v        = d.errv;
    assert_en    = d.aen;
    assert_cond  = d.acond;
    amone_en     = d.amen;
    amone_vec    = d.amvec;
    onehot_en    = d.ohen;
    onehot_vec   = d.ohvec;
    bus.bus_req  = d.req;
    bus.bus_ack  = d.ack;
    bus.bus_data = d.data;
  endtask

  task automatic applyStimulus(input string tag, input stim_t d, input exp_t x);
    @(negedge clk);
    drive(d);
    exp_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  // Reset lands mid-cycle so the clear must be asynchronous to be seen at once.
  task automatic doReset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b1;
    drive('0);
    #1;
    e = '0;
    checkOutput(tag, e);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(tag_q.pop_front(), exp_q.pop_front());
    end
  end

  initial begin : watchdog
    #100000;
    mismatched++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    logic [2:0] okv [4];
    okv = '{3'b100, 3'b010, 3'b001, 3'b000};
    drive('0);
    repeat (2) @(negedge clk);
    e = '0;
    checkOutput("reset_init", e);
    reset = 1'b0;

    // at-most-one-hot
    for (int i = 0; i < 4; i++) begin
      s = '0; s.amen = 1'b1; s.amvec = okv[i];
      applyStimulus("amone_ok", s, e);
    end
    s = '0; s.amvec = 3'b111;
    applyStimulus("amone_disabled", s, e);
    s = '0; s.amen = 1'b1; s.amvec = 3'b011;
    e.err = 16'd1; e.code = 3'd3; e.sticky = 1'b1; e.stop = 1'b1;
    applyStimulus("amone_fail", s, e);
    applyStimulus("amone_hold", '0, e);
    doReset("reset_after_amone");

    // exactly-one-hot
    s = '0; s.ohen = 1'b1; s.ohvec = 3'b010;
    applyStimulus("onehot_10", s, e);
    s.ohvec = 3'b001;
    applyStimulus("onehot_01", s, e);
    s = '0; s.ohvec = 3'b000;
    applyStimulus("onehot_disabled", s, e);
    s = '0; s.ohen = 1'b1; s.ohvec = 3'b000;
    e.err = 16'd1; e.code = 3'd4; e.sticky = 1'b1; e.stop = 1'b1;
    applyStimulus("onehot_00", s, e);
    s.ohvec = 3'b011;
    e.err = 16'd2;
    applyStimulus("onehot_11", s, e);
    doReset("reset_after_onehot");

    // clean handshake, then a stray acknowledge
    s = '0; s.req = 1'b1; s.data = 32'h0000feed;
    e.pend = 1'b1; e.data = 32'h0000feed;
    applyStimulus("hs_req", s, e);
    applyStimulus("hs_wait", '0, e);
    s = '0; s.ack = 1'b1;
    e.pend = 1'b0;
    applyStimulus("hs_ack", s, e);
    e.err = 16'd1; e.code = 3'd5; e.sticky = 1'b1; e.stop = 1'b1;
    applyStimulus("ack_no_req", s, e);
    doReset("reset_after_hs");

    // request while busy is flagged and not captured
    s = '0; s.req = 1'b1; s.data = 32'h00001111;
    e.pend = 1'b1; e.data = 32'h00001111;
    applyStimulus("busy_first", s, e);
    s.data = 32'h00002222;
    e.err = 16'd1; e.code = 3'd6; e.sticky = 1'b1; e.stop = 1'b1;
    applyStimulus("busy_second", s, e);
    doReset("reset_after_busy");

    // acknowledge timeout after 16 pending cycles, flagged once
    s = '0; s.req = 1'b1; s.data = 32'h0000abcd;
    e.pend = 1'b1; e.data = 32'h0000abcd;
    applyStimulus("to_req", s, e);
    for (int i = 1; i <= 15; i++) applyStimulus("to_wait", '0, e);
    e.pend = 1'b0; e.err = 16'd1; e.code = 3'd7; e.sticky = 1'b1; e.stop = 1'b1;
    applyStimulus("to_expire", '0, e);
    for (int i = 0; i < 3; i++) applyStimulus("to_once", '0, e);
    doReset("reset_after_timeout");

    // back-to-back: ack closes and req reopens in one cycle
    s = '0; s.req = 1'b1; s.data = 32'h0000000a;
    e.pend = 1'b1; e.data = 32'h0000000a;
    applyStimulus("b2b_req", s, e);
    applyStimulus("b2b_wait", '0, e);
    s = '0; s.req = 1'b1; s.ack = 1'b1; s.data = 32'h0000000b;
    e.data = 32'h0000000b;
    applyStimulus("b2b_ackreq", s, e);
    s = '0; s.ack = 1'b1;
    e.pend = 1'b0;
    applyStimulus("b2b_ack", s, e);
    s = '0; s.req = 1'b1; s.ack = 1'b1; s.data = 32'h0000000c;
    e.pend = 1'b1; e.data = 32'h0000000c;
    e.err = 16'd1; e.code = 3'd5; e.sticky = 1'b1; e.stop = 1'b1;
    applyStimulus("same_cycle_ack", s, e);
    doReset("reset_after_b2b");

    // several sources in one cycle: count all, latch the lowest code
    s = '0; s.aen = 1'b1; s.acond = 1'b0; s.amen = 1'b1; s.amvec = 3'b011;
    s.ohen = 1'b1; s.ohvec = 3'b000;
    e.err = 16'd3; e.code = 3'd2; e.sticky = 1'b1; e.stop = 1'b1;
    applyStimulus("multi_fail", s, e);
    s = '0; s.errv = 1'b1;
    e.err = 16'd4;
    applyStimulus("code_kept", s, e);
    doReset("reset_after_multi");

    // message counters
    s = '0; s.info = 1'b1; s.aen = 1'b1; s.acond = 1'b1;
    e.info = 16'd1;
    applyStimulus("info_1", s, e);
    e.info = 16'd2;
    applyStimulus("info_2", s, e);
    s = '0; s.warn = 1'b1;
    e.warn = 16'd1;
    applyStimulus("warn_1", s, e);
    applyStimulus("msg_idle", '0, e);
    s = '0; s.errv = 1'b1;
    e.err = 16'd1; e.code = 3'd1; e.sticky = 1'b1; e.stop = 1'b1;
    applyStimulus("err_msg", s, e);

    // reset mid-handshake drops the request silently
    doReset("reset_after_msgs");
    s = '0; s.req = 1'b1; s.data = 32'h00005555;
    e.pend = 1'b1; e.data = 32'h00005555;
    applyStimulus("mid_req", s, e);
    doReset("reset_mid_hs");
    s = '0; s.req = 1'b1; s.data = 32'h00006666;
    e.pend = 1'b1; e.data = 32'h00006666;
    applyStimulus("post_reset_req", s, e);
    s = '0; s.ack = 1'b1;
    e.pend = 1'b0;
    applyStimulus("post_reset_ack", s, e);
    applyStimulus("final_idle", '0, e);

    @(posedge clk);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
